vga_out_stage: RTL and testbench
================================

# vga_out_stage

Parametrised VGA output stage between the pixel generator (scan + graphic logic) and the panel pins. It aligns the sync/DE signals to a pixel pipeline of configurable depth. It reduces each colour channel from `IN_W` bits to a per-channel panel width using truncate, round-with-saturation, or 2x2 ordered dither, and registers every pin-level output. Mode changes take effect only at frame boundaries.

## Interface
Parameters:
- `IN_W`, 8: input bits per colour channel.
- `R_W`, 5: output red width; must satisfy 1 ≤ `R_W` ≤ `IN_W`.
- `G_W`, 6: output green width; must satisfy 1 ≤ `G_W` ≤ `IN_W`.
- `B_W`, 5: output blue width; must satisfy 1 ≤ `B_W` ≤ `IN_W`.
- `SYNC_DLY`, 1: cycles by which incoming colour lags incoming sync/DE; range 0..15.
- `SYNC_ACT`, 0: active level of hsync/vsync (0 = active-low).

Ports:
- `pix_clk` in 1: pixel clock; the only clock.
- `pix_rstn` in 1: reset, synchronous, active-low.
- `mode` in 2: 00 truncate, 01 round, 10 dither, 11 reserved (behaves as 00).
- `in_hsync`, `in_vsync`, `in_de` in 1 each: raw timing from the scanner.
- `in_r`, `in_g`, `in_b` in `IN_W` each: pixel colour, valid `SYNC_DLY` cycles after its DE.
- `vga_hsync`, `vga_vsync`, `vga_de` out 1 each: registered aligned timing.
- `vga_r` out `R_W`, `vga_g` out `G_W`, `vga_b` out `B_W`: registered reduced colour.
- `frame_start` out 1: one-cycle pulse coincident with the `vga_vsync` active edge.

## Operation
- **Delay line.** A `SYNC_DLY`-deep shift register carries hsync/vsync/DE. The signals after the delay line are called d_hs, d_vs and d_de. With `SYNC_DLY`=0 the delay line is a wire.
- **Position tracking, from delayed signals:**
  - x0 toggles on every d_de=1 cycle.
  - x0 clears on every cycle with d_de=0.
  - y0 toggles on each d_de falling edge.
  - y0 clears on the d_vs active edge.
- **Mode register.** `mode` is sampled into `mode_q` only on the d_vs active edge (transition to `SYNC_ACT`). `mode_q` is constant for a whole frame.
- **Per channel reduction.** Let D = `IN_W` − `W`.
  - D=0: pass-through in all modes.
  - Truncate: out = in[`IN_W`-1 -: `W`].
  - Round: s = in + 2^(D−1), computed in `IN_W`+1 bits. out = s[`IN_W`] ? all-ones : s[`IN_W`-1 -: `W`].
  - Dither: Bayer value b is 0 at (x0,y0)=(0,0), 2 at (1,0), 3 at (0,1), 1 at (1,1).
  - Dither offset: b<<(D−2) if D≥2; b[1] if D=1. Saturate as in Round.
- **Blanking.** When d_de=0, all colour outputs register 0, regardless of input.
- **`frame_start`.** High for exactly one cycle, on the cycle `vga_vsync` first shows `SYNC_ACT`.

## Timing
- Sync and DE latency, in → `vga_*`: `SYNC_DLY`+1 cycles.
- Colour latency, `in_*` → `vga_*`: 1 cycle. Output colour pairs with the DE it was generated for.
- Reset values, on the first edge with `pix_rstn`=0:
  - Delay line: hsync/vsync taps = ~`SYNC_ACT`, DE taps = 0.
  - Outputs: `vga_hsync`/`vga_vsync` = ~`SYNC_ACT`, `vga_de`=0, all colour outputs 0, `frame_start`=0.
  - Internal state: `mode_q`=00, x0=0, y0=0.
- Reset mid-frame: the outputs above hold their reset values while `pix_rstn`=0.
- After reset release, outputs follow inputs with the normal latency once the delay line refills. No spurious `frame_start` is produced by the reset-released inactive-to-active path unless d_vs actually reaches the active edge.
- Simultaneous d_vs edge and d_de falling edge: y0 clear wins.
- A `mode` change mid-frame is ignored until the next d_vs active edge.
- The d_vs active edge is evaluated on the same cycle that updates `mode_q`. The first pixel of the new frame uses the new mode.

## Test plan
- **Latency.** `SYNC_DLY`=3, single-cycle `in_hsync` pulse at cycle 10 → `vga_hsync` active at cycle 14 only. Colour driven at cycle 13 with `in_de` high at cycle 10 appears at cycle 14.
- **Truncate / blanking.** Mode 00, `in_r`=0xFF, `in_g`=0x83, `in_b`=0x07, DE high → `vga_r`=31, `vga_g`=32, `vga_b`=0. Same inputs with DE low → all colour outputs 0.
- **Round / saturation.** Mode 01, `in_r`=0x0B → 1. `in_r`=0xFC → 31, saturated with no wrap. `in_g`=0xFE → 63.
- **Dither.** Mode 10, `in_r`=0x04 constant over 2 lines × 2 pixels → `vga_r` = 0,1 on line 0 and 1,0 on line 1. After the next vsync the pattern restarts at (0,0).
- **Frame-boundary mode change.** Switch `mode` 00→01 mid-frame → output unchanged until the first pixel after the next vsync active edge. `frame_start` pulses once, aligned with `vga_vsync`.
- **Reset mid-frame.** `pix_rstn` low for 2 cycles during active video → `vga_de`=0, colour outputs 0, syncs inactive on the next edge. `mode_q` returns to truncate.

Source files
------------

// File: rtl/vga_out_stage.sv
// VGA output stage: aligns sync/DE to the colour pipeline, reduces each colour
// channel to panel width (truncate / round / 2x2 dither) and registers all pins.
module vga_out_stage #(
   parameter int unsigned IN_W     = 8,
   parameter int unsigned R_W      = 5,
   parameter int unsigned G_W      = 6,
   parameter int unsigned B_W      = 5,
   parameter int unsigned SYNC_DLY = 1,
   parameter logic        SYNC_ACT = 1'b0
) (
   input  logic            pix_clk,
   input  logic            pix_rstn,
   input  logic [1:0]      mode,
   input  logic            in_hsync,
   input  logic            in_vsync,
   input  logic            in_de,
   input  logic [IN_W-1:0] in_r,
   input  logic [IN_W-1:0] in_g,
   input  logic [IN_W-1:0] in_b,
   output logic            vga_hsync,
   output logic            vga_vsync,
   output logic            vga_de,
   output logic [R_W-1:0]  vga_r,
   output logic [G_W-1:0]  vga_g,
   output logic [B_W-1:0]  vga_b,
   output logic            frame_start
);

   localparam logic [1:0] MODE_TRUNC  = 2'b00;
   localparam logic [1:0] MODE_ROUND  = 2'b01;
   localparam logic [1:0] MODE_DITHER = 2'b10;

   logic       d_hs, d_vs, d_de;
   logic       x0, y0;
   logic [1:0] mode_q;
   logic [1:0] bayer;
   logic       vs_edge, de_fall;

   generate
      if (SYNC_DLY == 0) begin : g_nodly
         assign d_hs = in_hsync;
         assign d_vs = in_vsync;
         assign d_de = in_de;
      end else begin : g_dly
         logic [SYNC_DLY-1:0] hs_sr, vs_sr, de_sr;
         always_ff @(posedge pix_clk) begin
            if (!pix_rstn) begin
               hs_sr <= {SYNC_DLY{~SYNC_ACT}};
               vs_sr <= {SYNC_DLY{~SYNC_ACT}};
               de_sr <= '0;
            end else begin
               for (int unsigned i = SYNC_DLY - 1; i > 0; i--) begin
                  hs_sr[i] <= hs_sr[i-1];
                  vs_sr[i] <= vs_sr[i-1];
                  de_sr[i] <= de_sr[i-1];
               end
               hs_sr[0] <= in_hsync;
               vs_sr[0] <= in_vsync;
               de_sr[0] <= in_de;
            end
         end
         assign d_hs = hs_sr[SYNC_DLY-1];
         assign d_vs = vs_sr[SYNC_DLY-1];
         assign d_de = de_sr[SYNC_DLY-1];
      end
   endgenerate

   // The registered outputs double as the previous-cycle copies of d_vs / d_de.
   assign vs_edge = (d_vs == SYNC_ACT) && (vga_vsync != SYNC_ACT);
   assign de_fall = vga_de && !d_de;
   assign bayer   = {x0 ^ y0, y0};

   // Result is right-aligned in the low w bits; D=0 falls out as pass-through.
   function automatic logic [IN_W-1:0] reduce(input logic [IN_W-1:0] v,
                                               input int unsigned     w,
                                               input logic [1:0]      m,
                                               input logic [1:0]      bay);
      int unsigned   d;
      logic [IN_W:0] off, s;
      d   = IN_W - w;
      off = '0;
      case (m)
         MODE_ROUND:
            if (d >= 1) off = {{IN_W{1'b0}}, 1'b1} << (d - 1);
         MODE_DITHER:
            if (d >= 2)      off = {{(IN_W-1){1'b0}}, bay} << (d - 2);
            else if (d == 1) off[0] = bay[1];
         MODE_TRUNC: off = '0;
         default:    off = '0;
      endcase
      s = {1'b0, v} + off;
      if (s[IN_W]) return {IN_W{1'b1}} >> d;
      return s[IN_W-1:0] >> d;
   endfunction

   always_ff @(posedge pix_clk) begin
      if (!pix_rstn) begin
         vga_hsync   <= ~SYNC_ACT;
         vga_vsync   <= ~SYNC_ACT;
         vga_de      <= 1'b0;
         vga_r       <= '0;
         vga_g       <= '0;
         vga_b       <= '0;
         frame_start <= 1'b0;
         mode_q      <= MODE_TRUNC;
         x0          <= 1'b0;
         y0          <= 1'b0;
      end else begin
         vga_hsync   <= d_hs;
         vga_vsync   <= d_vs;
         vga_de      <= d_de;
         frame_start <= vs_edge;
         if (d_de) begin
            vga_r <= R_W'(reduce(in_r, R_W, mode_q, bayer));
            vga_g <= G_W'(reduce(in_g, G_W, mode_q, bayer));
            vga_b <= B_W'(reduce(in_b, B_W, mode_q, bayer));
         end else begin
            vga_r <= '0;
            vga_g <= '0;
            vga_b <= '0;
         end
         if (vs_edge) mode_q <= mode;
         x0 <= d_de & ~x0;
         if (vs_edge)      y0 <= 1'b0;
         else if (de_fall) y0 <= ~y0;
      end
   end

endmodule

// File: tb/tb_vga_out_stage.sv
// Scoreboard bench for vga_out_stage: randomized colour/mode over a small raster,
// expected pin values from an integer reference model.
module tb_vga_out_stage;

   localparam int   IN_W = 8;
   localparam int   R_W  = 5;
   localparam int   G_W  = 6;
   localparam int   B_W  = 5;
   localparam int   DLY  = 3;
   localparam logic ACT  = 1'b0;
   localparam int   HT   = 12;
   localparam int   VT   = 10;

   logic            pix_clk, pix_rstn;
   logic [1:0]      mode;
   logic            in_hsync, in_vsync, in_de;
   logic [IN_W-1:0] in_r, in_g, in_b;
   logic            vga_hsync, vga_vsync, vga_de, frame_start;
   logic [R_W-1:0]  vga_r;
   logic [G_W-1:0]  vga_g;
   logic [B_W-1:0]  vga_b;

   vga_out_stage #(
      .IN_W(IN_W), .R_W(R_W), .G_W(G_W), .B_W(B_W),
      .SYNC_DLY(DLY), .SYNC_ACT(ACT)
   ) dut (
      .pix_clk(pix_clk), .pix_rstn(pix_rstn), .mode(mode),
      .in_hsync(in_hsync), .in_vsync(in_vsync), .in_de(in_de),
      .in_r(in_r), .in_g(in_g), .in_b(in_b),
      .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_de(vga_de),
      .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
      .frame_start(frame_start)
   );

   initial pix_clk = 1'b0;
   always #5 pix_clk = ~pix_clk;

   typedef struct { logic hs; logic vs; logic de; } sync_t;
   typedef struct {
      logic hs; logic vs; logic de; logic fs;
      logic [R_W-1:0] r; logic [G_W-1:0] g; logic [B_W-1:0] b;
   } exp_t;

   exp_t  sbq[$];
   sync_t dq[$];

   int vectors = 0;
   int miscompares = 0;

   // reference state: pixel index in line, line index in frame, latched mode
   int   xc, yc, mode_l;
   logic p_vs, p_de;
   int   bay_tab [2][2] = '{'{0, 2}, '{3, 1}};
   int   specials [8] = '{8'h00, 8'hFF, 8'hFC, 8'hFE, 8'h0B, 8'h04, 8'h83, 8'h07};

   function automatic int chan_model(int v, int w, int m, int bay);
      int d, off, q, mx;
      d  = IN_W - w;
      mx = (1 << w) - 1;
      off = 0;
      if (m == 1 && d >= 1) off = 1 << (d - 1);
      if (m == 2) off = (d >= 2) ? (bay << (d - 2)) : (d == 1 ? bay / 2 : 0);
      q = (v + off) >> d;
      return (q > mx) ? mx : q;
   endfunction

   function automatic int pick_colour();
      if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 7)];
      return int'($urandom_range(0, 255));
   endfunction

   task automatic model_step();
      exp_t  e;
      sync_t cur, d;
      logic  vs_edge, fall;
      int    bay;
      if (!pix_rstn) begin
         dq.delete();
         for (int i = 0; i < DLY; i++) begin
            cur.hs = ~ACT; cur.vs = ~ACT; cur.de = 1'b0;
            dq.push_back(cur);
         end
         xc = 0; yc = 0; mode_l = 0; p_vs = ~ACT; p_de = 1'b0;
         e.hs = ~ACT; e.vs = ~ACT; e.de = 1'b0; e.fs = 1'b0;
         e.r = '0; e.g = '0; e.b = '0;
      end else begin
         cur.hs = in_hsync; cur.vs = in_vsync; cur.de = in_de;
         dq.push_back(cur);
         d = dq.pop_front();
         vs_edge = (d.vs == ACT) && (p_vs != ACT);
         fall    = p_de && !d.de;
         bay     = bay_tab[yc % 2][xc % 2];
         e.hs = d.hs; e.vs = d.vs; e.de = d.de; e.fs = vs_edge;
         e.r = d.de ? R_W'(chan_model(int'(in_r), R_W, mode_l, bay)) : '0;
         e.g = d.de ? G_W'(chan_model(int'(in_g), G_W, mode_l, bay)) : '0;
         e.b = d.de ? B_W'(chan_model(int'(in_b), B_W, mode_l, bay)) : '0;
         if (vs_edge) mode_l = int'(mode);
         xc = d.de ? xc + 1 : 0;
         if (vs_edge)   yc = 0;
         else if (fall) yc = yc + 1;
         p_vs = d.vs; p_de = d.de;
      end
      sbq.push_back(e);
   endtask

   // monitor: one entry is pushed per active edge, checked just after it
   always @(posedge pix_clk) begin
      exp_t e;
      #1;
      if (sbq.size() > 0) begin
         e = sbq.pop_front();
         vectors++;
         if (vga_hsync !== e.hs || vga_vsync !== e.vs || vga_de !== e.de ||
             frame_start !== e.fs || vga_r !== e.r || vga_g !== e.g || vga_b !== e.b) begin
            miscompares++;
            $display("FAIL vec%0d t=%0t: got hs=%b vs=%b de=%b fs=%b r=%0d g=%0d b=%0d, need hs=%b vs=%b de=%b fs=%b r=%0d g=%0d b=%0d",
                     vectors, $time, vga_hsync, vga_vsync, vga_de, frame_start, vga_r, vga_g, vga_b,
                     e.hs, e.vs, e.de, e.fs, e.r, e.g, e.b);
         end
      end
   end

   initial begin
      int t, hc, vc, rst_at;
      pix_rstn = 1'b0; mode = 2'b00;
      in_hsync = ~ACT; in_vsync = ~ACT; in_de = 1'b0;
      in_r = '0; in_g = '0; in_b = '0;
      rst_at = 6 * HT * VT + 2 * HT + 3;
      for (t = 0; t < 14 * HT * VT; t++) begin
         @(negedge pix_clk);
         hc = t % HT;
         vc = (t / HT) % VT;
         pix_rstn = !(t < 3 || (t >= rst_at && t < rst_at + 2));
         in_de    = (hc < 8) && (vc < 6);
         in_hsync = (hc == 9 || hc == 10) ? ACT : ~ACT;
         // vsync rises on the same cycle DE falls at the end of the last active line
         in_vsync = ((vc == 5 && hc >= 8) || vc == 6 || (vc == 7 && hc < 8)) ? ACT : ~ACT;
         if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
         in_r = IN_W'(pick_colour());
         in_g = IN_W'(pick_colour());
         in_b = IN_W'(pick_colour());
         model_step();
      end
      repeat (4) @(posedge pix_clk);
      #2;
      if (sbq.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d entries left, need 0", sbq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
